// File: rtl/aes256_dec_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the AES-256 inverse cipher.
package aes_dec_pkg;

    localparam int unsigned AES_ROUNDS = 14;
    localparam int unsigned N          = 16;

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        ARK,
        SHF,
        SUB,
        MIX,
        DONE
    } dec_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (covers 09/0b/0d/0e).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? b  : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    // Column c occupies bytes 4c..4c+3 (row 0 in the lowest byte).
    function automatic logic [8*N-1:0] inv_mix_columns(input logic [8*N-1:0] s);
        logic [8*N-1:0] r;
        logic [7:0]     a0;
        logic [7:0]     a1;
        logic [7:0]     a2;
        logic [7:0]     a3;
        r = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[7'(32*c)      +: 8];
            a1 = s[7'(32*c + 8)  +: 8];
            a2 = s[7'(32*c + 16) +: 8];
            a3 = s[7'(32*c + 24) +: 8];
            r[7'(32*c)      +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            r[7'(32*c + 8)  +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            r[7'(32*c + 16) +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            r[7'(32*c + 24) +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return r;
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [8*N-1:0] inv_shift_rows(input logic [8*N-1:0] s);
        logic [8*N-1:0] o;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                o[7'(8*(r + 4*c)) +: 8] = s[7'(8*(r + 4*((c + 4 - r) % 4))) +: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes256_dec_if.sv
// Host bus and key-fetch signals of the AES-256 decryptor.
interface aes256_dec_if;
    import aes_dec_pkg::*;

    logic           addr;
    logic [31:0]    wr_data;
    logic           req_axi_in;
    logic [3:0]     key_sel;
    logic [8*N-1:0] round_key;
    logic [8*N-1:0] decData;
    logic           done;
    logic           busy;

    modport master (
        output addr, wr_data, req_axi_in, round_key,
        input  key_sel, decData, done, busy
    );

    modport slave (
        input  addr, wr_data, req_axi_in, round_key,
        output key_sel, decData, done, busy
    );
endinterface

// File: rtl/aes256_dec_rom256.sv
// Inverse AES S-box, registered output with one cycle of latency.
module mod_dec_rom256 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    // Table lookup into the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else begin
            data <= INV_SBOX[addr];
        end
    end

endmodule

// File: rtl/aes256_dec.sv
// Iterative AES-256 decryptor: host loads four ciphertext words and sets
// ctrl[0]; round keys are fetched one per round through key_sel/round_key.
module aes256_dec
    import aes_dec_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           addr,
    input  logic [31:0]    wr_data,
    input  logic           req_axi_in,
    output logic [3:0]     key_sel,
    input  logic [8*N-1:0] round_key,
    output logic [8*N-1:0] decData,
    output logic           done,
    output logic           busy
);

    dec_state_e     state_q;
    logic [3:0]     rnd_q;
    logic [7:0]     ctrl_q;
    logic [1:0]     wcnt_q;
    logic           ct_full_q;
    logic [8*N-1:0] ct_q;
    logic [8*N-1:0] st_q;
    logic [8*N-1:0] dec_q;
    logic [4:0]     sub_cnt_q;
    logic [3:0]     key_sel_q;
    logic           done_q;
    logic           busy_q;

    logic           ctrl_wr;
    logic           ct_wr;
    logic [3:0]     sub_wr_idx;
    logic [7:0]     sbox_addr;
    logic [7:0]     sbox_data;
    logic [8*N-1:0] ark_d;
    logic [8*N-1:0] mix_d;
    logic [8*N-1:0] shf_d;
    logic           unused_ctrl;

    assign ctrl_wr     = req_axi_in & ~addr;
    assign ct_wr       = req_axi_in & addr & ~busy_q;
    assign unused_ctrl = ^ctrl_q[7:1];

    // The ROM answers one cycle late, so byte i is written back while
    // byte i+1 is being looked up; count 16 only drains the last result.
    assign sub_wr_idx = sub_cnt_q[3:0] - 4'd1;
    assign sbox_addr  = st_q[{sub_cnt_q[3:0], 3'b000} +: 8];

    mod_dec_rom256 u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (sbox_addr),
        .data  (sbox_data)
    );

    // Round transforms applied to the current state.
    always_comb begin
        ark_d = st_q ^ round_key;
        mix_d = inv_mix_columns(st_q);
        shf_d = inv_shift_rows(st_q);
    end

    // Ciphertext word buffer, filled only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ct_q   <= '0;
            wcnt_q <= '0;
        end else if (ct_wr) begin
            ct_q[{wcnt_q, 5'b00000} +: 32] <= wr_data;
            wcnt_q                         <= wcnt_q + 2'd1;
        end
    end

    // Control register, buffer-full flag and round sequencing FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rnd_q     <= '0;
            ctrl_q    <= '0;
            ct_full_q <= 1'b0;
            st_q      <= '0;
            dec_q     <= '0;
            sub_cnt_q <= '0;
            key_sel_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ct_wr && wcnt_q == 2'd3) begin
                ct_full_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (ctrl_q[0] && ct_full_q) begin
                        state_q   <= KEY;
                        rnd_q     <= 4'(AES_ROUNDS);
                        key_sel_q <= 4'(AES_ROUNDS);
                        st_q      <= ct_q;
                        ct_full_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                KEY: begin
                    state_q <= ARK;
                end
                ARK: begin
                    st_q <= ark_d;
                    // The final key addition goes straight to the output
                    // register so done lines up with the DONE state.
                    if (rnd_q == 4'd0) begin
                        state_q <= DONE;
                        dec_q   <= ark_d;
                        done_q  <= 1'b1;
                    end else if (rnd_q == 4'(AES_ROUNDS)) begin
                        state_q <= SHF;
                    end else begin
                        state_q <= MIX;
                    end
                end
                MIX: begin
                    st_q    <= mix_d;
                    state_q <= SHF;
                end
                SHF: begin
                    st_q      <= shf_d;
                    rnd_q     <= rnd_q - 4'd1;
                    sub_cnt_q <= '0;
                    state_q   <= SUB;
                end
                SUB: begin
                    if (sub_cnt_q != 5'd0) begin
                        st_q[{sub_wr_idx, 3'b000} +: 8] <= sbox_data;
                    end
                    if (sub_cnt_q == 5'd16) begin
                        state_q   <= KEY;
                        key_sel_q <= rnd_q;
                    end else begin
                        sub_cnt_q <= sub_cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (ctrl_wr) begin
                ctrl_q <= wr_data[7:0];
            end else if (state_q == DONE) begin
                ctrl_q[0] <= 1'b0;
            end
        end
    end

    assign key_sel = key_sel_q;
    assign decData = dec_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_aes256_dec.sv
// Scoreboard bench for aes256_dec: expected plaintexts are queued at start,
// a monitor pops and compares on every done pulse.
module tb_aes256_dec;

    logic        clk = 1'b0;
    logic        reset;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes256_dec_if bus();

    aes256_dec dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (bus.addr),
        .wr_data    (bus.wr_data),
        .req_axi_in (bus.req_axi_in),
        .key_sel    (bus.key_sel),
        .round_key  (bus.round_key),
        .decData    (bus.decData),
        .done       (bus.done),
        .busy       (bus.busy)
    );

    typedef struct {
        logic [127:0] pt;
        bit           chk_lat;
        int unsigned  start;
    } exp_t;

    exp_t         exp_q[$];
    int unsigned  n_vec  = 0;
    int unsigned  n_miss = 0;
    int unsigned  n_done = 0;
    logic [7:0]   sb [256];
    logic [127:0] rk [15];

    localparam logic [127:0] CT1 = 128'h8960494b_9049fcea_bf456751_cab7a28e;
    localparam logic [127:0] PT1 = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] PT2 = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] PT3 = 128'hdeadbeef_00000000_ffffffff_a5a5a5a5;
    localparam logic [127:0] PT4 = 128'h0;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // Forward S-box from multiplicative inverse plus affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gm(inv, 8'(x));
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [255:0] key);
        logic [7:0] w [60][4];
        logic [7:0] t [4];
        logic [7:0] rc;
        logic [7:0] tmp;
        rc = 8'h01;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
        for (int i = 8; i < 60; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 8 == 0) begin
                tmp  = t[0];
                t[0] = sb[t[1]] ^ rc;
                t[1] = sb[t[2]];
                t[2] = sb[t[3]];
                t[3] = sb[tmp];
                rc   = xt(rc);
            end else if (i % 8 == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sb[t[j]];
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-8][j] ^ t[j];
        end
        for (int r = 0; r < 15; r++)
            for (int k = 0; k < 16; k++) rk[r][8*k +: 8] = w[4*r + k/4][k%4];
    endtask

    // Forward cipher, used to derive ciphertexts for chosen plaintexts.
    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ rk[0][8*k +: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row + 4*col] = t[row + 4*((col + row) % 4)];
            if (r != 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[r][8*k +: 8];
        end
        for (int k = 0; k < 16; k++) o[8*k +: 8] = s[k];
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic wr(input logic a, input logic [31:0] d, output int unsigned cap);
        @(posedge clk); #1;
        bus.addr       = a;
        bus.wr_data    = d;
        bus.req_axi_in = 1'b1;
        @(posedge clk); #1;
        bus.req_axi_in = 1'b0;
        cap = cyc;
    endtask

    task automatic load_words(input logic [127:0] ct, input int first, input int last,
                              output int unsigned cap);
        for (int i = first; i <= last; i++) wr(1'b1, ct[32*i +: 32], cap);
    endtask

    task automatic start_dec(input logic [127:0] pt, input bit chk);
        int unsigned c;
        wr(1'b0, 32'h0000_0001, c);
        exp_q.push_back('{pt: pt, chk_lat: chk, start: c});
    endtask

    task automatic wait_drain(input string name);
        int unsigned k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: done not seen within 400 cycles, required one done pulse", name);
            exp_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Round-key responder: looks up the key for the requested index.
    initial begin
        bus.round_key = '0;
        forever begin
            @(posedge clk); #1;
            bus.round_key = rk[bus.key_sel];
        end
    end

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("decData", bus.decData, e.pt);
                    if (e.chk_lat) check("latency", 128'(cyc - e.start), 128'd296);
                    @(negedge clk);
                    check("done_width", 128'(bus.done), 128'd0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] key;
        int unsigned  c;
        logic [127:0] ct2, ct3, ct4;

        reset          = 1'b1;
        bus.addr       = 1'b0;
        bus.wr_data    = '0;
        bus.req_axi_in = 1'b0;

        build_sbox();
        for (int k = 0; k < 32; k++) key[8*k +: 8] = 8'(k);
        expand_key(key);
        ct2 = encrypt(PT2);
        ct3 = encrypt(PT3);
        ct4 = encrypt(PT4);

        #2;
        check("reset_key_sel", 128'(bus.key_sel), 128'd0);
        check("reset_decData", bus.decData, 128'd0);
        check("reset_done", 128'(bus.done), 128'd0);
        check("reset_busy", 128'(bus.busy), 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // FIPS-197 AES-256 vector with exact latency.
        load_words(CT1, 0, 3, c);
        start_dec(PT1, 1'b1);
        repeat (3) @(posedge clk);
        #1 check("busy_running", 128'(bus.busy), 128'd1);
        wait_drain("fips");

        // Ciphertext writes while busy are dropped (three to misalign wcnt).
        load_words(ct2, 0, 3, c);
        start_dec(PT2, 1'b1);
        wr(1'b1, 32'h5555aaaa, c);
        wr(1'b1, 32'h12345678, c);
        wr(1'b1, 32'hdeadbeef, c);
        wait_drain("busy_writes");

        // ctrl[0] self-clears: a full buffer alone must not restart.
        load_words(ct3, 0, 3, c);
        repeat (20) @(posedge clk);
        #1 check("no_restart_busy", 128'(bus.busy), 128'd0);
        start_dec(PT3, 1'b1);
        wait_drain("after_clear");

        // Back-to-back runs.
        load_words(ct4, 0, 3, c);
        start_dec(PT4, 1'b1);
        wait_drain("b2b_a");
        load_words(CT1, 0, 3, c);
        start_dec(PT1, 1'b1);
        wait_drain("b2b_b");

        // Start with a half-filled buffer waits for the last word.
        load_words(ct2, 0, 1, c);
        wr(1'b0, 32'h0000_0001, c);
        repeat (30) @(posedge clk);
        #1 check("partial_busy", 128'(bus.busy), 128'd0);
        load_words(ct2, 2, 3, c);
        exp_q.push_back('{pt: PT2, chk_lat: 1'b1, start: c});
        wait_drain("partial");

        // Reset in the middle of the SUB step of round 7.
        load_words(ct3, 0, 3, c);
        start_dec(PT3, 1'b1);
        repeat (155) @(posedge clk);
        #1 check("key_sel_round7", 128'(bus.key_sel), 128'd7);
        #2 reset = 1'b1;
        #1;
        check("abort_key_sel", 128'(bus.key_sel), 128'd0);
        check("abort_decData", bus.decData, 128'd0);
        check("abort_done", 128'(bus.done), 128'd0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        c = n_done;
        wr(1'b0, 32'h0000_0001, c);
        c = n_done;
        repeat (350) @(posedge clk);
        #1;
        check("abort_no_done", 128'(n_done), 128'(c));
        check("abort_idle_busy", 128'(bus.busy), 128'd0);
        load_words(CT1, 0, 3, c);
        exp_q.push_back('{pt: PT1, chk_lat: 1'b1, start: c});
        wait_drain("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
